// File: rtl/tt_spi_io_pkg.sv
// Shared constants for the SPI register front-end: register addresses, frame size, FSM states.
package tt_spi_io_pkg;

   localparam int unsigned FRAME_BITS = 16;

   localparam logic [1:0] ADDR_UO  = 2'd0;
   localparam logic [1:0] ADDR_UIO = 2'd1;
   localparam logic [1:0] ADDR_OE  = 2'd2;
   localparam logic [1:0] ADDR_ID  = 2'd3;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/tt_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle rise/fall pulses.
module tt_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/tt_spi_io_regs.sv
// SPI mode-0 register front-end driving the uo/uio/oe pad registers.
// Optional MISO read-back is enabled by defining TT_SPI_READBACK_EN.
module tt_spi_io_regs
   import tt_spi_io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  ID_VALUE    = 8'hA5,
   parameter logic [7:0]  OE_RESET    = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic [7:0] reg_uo,
   output logic [7:0] reg_uio,
   output logic [7:0] reg_oe,
   output logic       wr_strobe
);

   localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

   logic sclk_rise, sclk_fall, unused_sclk_lvl;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s, unused_mosi_rise, unused_mosi_fall;

   tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (spi_sclk),
      .q_o    (unused_sclk_lvl),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   // cs_n idles high so reset release does not look like a frame start.
   tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (spi_cs_n),
      .q_o    (cs_s),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (spi_mosi),
      .q_o    (mosi_s),
      .rise_o (unused_mosi_rise),
      .fall_o (unused_mosi_fall)
   );

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] shift_q, shift_d;
   logic [7:0]  uo_q, uo_d, uio_q, uio_d, oe_q, oe_d;
   logic        strobe_q, strobe_d;
   logic        last_rise;
   logic        unused_rsvd;

   assign last_rise   = sclk_rise && (cnt_q == LAST_BIT);
   assign unused_rsvd = ^shift_q[14:10];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      uo_d     = uo_q;
      uio_d    = uio_q;
      oe_d     = oe_q;
      strobe_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         SHIFT: begin
            if (sclk_rise) begin
               shift_d = {shift_q[14:0], mosi_s};
               cnt_d   = cnt_q + 5'd1;
            end
            // A 16th edge coinciding with cs_n rising still completes the frame.
            if (last_rise) begin
               state_d = COMMIT;
            end else if (cs_rise) begin
               state_d = IDLE;
            end
         end
         COMMIT: begin
            state_d = DONE;
            if (!shift_q[15] && (shift_q[9:8] != ADDR_ID)) begin
               strobe_d = 1'b1;
               case (shift_q[9:8])
                  ADDR_UO:  uo_d  = shift_q[7:0];
                  ADDR_UIO: uio_d = shift_q[7:0];
                  ADDR_OE:  oe_d  = shift_q[7:0];
                  default:  ;
               endcase
            end
         end
         DONE: begin
            if (cs_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         uo_q     <= '0;
         uio_q    <= '0;
         oe_q     <= OE_RESET;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         uo_q     <= uo_d;
         uio_q    <= uio_d;
         oe_q     <= oe_d;
         strobe_q <= strobe_d;
      end
   end

   assign reg_uo    = uo_q;
   assign reg_uio   = uio_q;
   assign reg_oe    = oe_q;
   assign wr_strobe = strobe_q;

`ifdef TT_SPI_READBACK_EN
   logic [7:0] rd_q, rd_d, rd_sel;
   logic       miso_q, miso_d;

   // On the 8th rising edge the address is {shift_q[0], mosi_s} and R/nW sits in shift_q[6].
   always_comb begin
      rd_sel = '0;
      case ({shift_q[0], mosi_s})
         ADDR_UO:  rd_sel = uo_q;
         ADDR_UIO: rd_sel = uio_q;
         ADDR_OE:  rd_sel = oe_q;
         default:  rd_sel = ID_VALUE;
      endcase
      rd_d   = rd_q;
      miso_d = miso_q;
      if (state_q == IDLE && cs_fall) begin
         rd_d   = '0;
         miso_d = 1'b0;
      end else if (state_q == SHIFT) begin
         if (sclk_rise && cnt_q == 5'd7) begin
            rd_d = shift_q[6] ? rd_sel : 8'h00;
         end else if (sclk_fall && cnt_q >= 5'd8 && cnt_q <= LAST_BIT) begin
            miso_d = rd_q[7];
            rd_d   = {rd_q[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q   <= '0;
         miso_q <= 1'b0;
      end else begin
         rd_q   <= rd_d;
         miso_q <= miso_d;
      end
   end

   assign spi_miso = miso_q;
`else
   logic unused_sclk_fall;
   logic unused_id;

   assign unused_sclk_fall = sclk_fall;
   assign unused_id        = ^ID_VALUE;
   assign spi_miso         = 1'b0;
`endif

endmodule

// File: tb/tb_tt_spi_io_regs.sv
// Scoreboard bench for tt_spi_io_regs: directed frames followed by random frames.
module tb_tt_spi_io_regs;
   import tt_spi_io_pkg::*;

   localparam int HALF = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_sclk = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic [7:0] reg_uo, reg_uio, reg_oe;
   logic       wr_strobe;

   int n_tests = 0;
   int n_fail  = 0;
   int strobe_cnt = 0;

   logic [7:0]  model_reg [4];
   logic [23:0] exp_q [$];

   tt_spi_io_regs dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_sclk  (spi_sclk),
      .spi_cs_n  (spi_cs_n),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .reg_uo    (reg_uo),
      .reg_uio   (reg_uio),
      .reg_oe    (reg_oe),
      .wr_strobe (wr_strobe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      model_reg[0] = 8'h00;
      model_reg[1] = 8'h00;
      model_reg[2] = 8'h00;
      model_reg[3] = 8'hA5;
   endtask

   // Monitor: every write commit must match the next expected register snapshot.
   always @(negedge clk) begin
      if (rst_n && wr_strobe) begin
         strobe_cnt++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_unexpected: got strobe with regs %h, expected none",
                     {reg_uo, reg_uio, reg_oe});
         end else begin
            check("strobe_regs", 32'({reg_uo, reg_uio, reg_oe}), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic reset_mid_frame();
      #1 rst_n = 1'b0;
      #20;
      check("rst_uo", 32'(reg_uo), 32'h00);
      check("rst_uio", 32'(reg_uio), 32'h00);
      check("rst_oe", 32'(reg_oe), 32'h00);
      check("rst_miso", 32'(spi_miso), 32'h0);
      check("rst_fsm_idle", 32'(dut.state_q), 32'(IDLE));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic spi_frame(input logic [15:0] w, input int nedges, input bit cs_last,
                            input int rst_at, output logic [7:0] rd);
      rd = '0;
      spi_cs_n = 1'b0;
      #(HALF);
      for (int i = 0; i < nedges; i++) begin
         if (i == rst_at) reset_mid_frame();
         spi_mosi = (i < 16) ? w[15-i] : 1'($urandom);
         #(HALF);
         if (i >= 8 && i < 16) rd[15-i] = spi_miso;
         spi_sclk = 1'b1;
         if (cs_last && i == nedges - 1) spi_cs_n = 1'b1;
         #(HALF);
         spi_sclk = 1'b0;
      end
      #(HALF);
      spi_cs_n = 1'b1;
      #(HALF * 3);
      spi_mosi = 1'b0;
   endtask

   task automatic run_frame(input logic [15:0] w, input int nedges, input bit cs_last,
                            input int rst_at);
      logic [7:0] rd, exp_rd;
      int         a;
      bit         full;
      a      = int'(w[9:8]);
      full   = (nedges >= 16) && (rst_at < 0);
      exp_rd = 8'h00;
`ifdef TT_SPI_READBACK_EN
      if (w[15]) exp_rd = model_reg[a];
`endif
      if (full && !w[15] && a != 3) begin
         model_reg[a] = w[7:0];
         exp_q.push_back({model_reg[0], model_reg[1], model_reg[2]});
      end
      spi_frame(w, nedges, cs_last, rst_at, rd);
      check("strobe_missing", 32'(exp_q.size()), 32'd0);
      check("reg_uo", 32'(reg_uo), 32'(model_reg[0]));
      check("reg_uio", 32'(reg_uio), 32'(model_reg[1]));
      check("reg_oe", 32'(reg_oe), 32'(model_reg[2]));
`ifdef TT_SPI_READBACK_EN
      if (full && w[15]) check("miso_read", 32'(rd), 32'(exp_rd));
`else
      if (full) check("miso_zero", 32'(rd), 32'(exp_rd));
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      model_reset();
      #25;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      check("init_uo", 32'(reg_uo), 32'h00);
      check("init_uio", 32'(reg_uio), 32'h00);
      check("init_oe", 32'(reg_oe), 32'h00);
      check("init_miso", 32'(spi_miso), 32'h0);
      check("init_strobe", 32'(wr_strobe), 32'h0);

      s0 = strobe_cnt;
      run_frame(16'h02FF, 16, 1'b0, -1);
      run_frame(16'h015A, 16, 1'b0, -1);
      check("two_strobes", 32'(strobe_cnt - s0), 32'd2);

      s0 = strobe_cnt;
      run_frame(16'h0033, 9, 1'b0, -1);
      check("short_no_strobe", 32'(strobe_cnt - s0), 32'd0);

      run_frame(16'h00C3, 20, 1'b0, -1);
      run_frame(16'h8300, 16, 1'b0, -1);
      run_frame(16'h8100, 16, 1'b0, -1);
      run_frame(16'hFE77, 16, 1'b0, -1);
      run_frame(16'h0077, 16, 1'b1, -1);

      s0 = strobe_cnt;
      run_frame(16'h01AA, 16, 1'b0, 12);
      check("rst_frame_no_strobe", 32'(strobe_cnt - s0), 32'd0);
      run_frame(16'h0111, 16, 1'b0, -1);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] w;
         int          ne;
         bit          cl;
         w  = 16'($urandom);
         ne = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                          : int'($urandom_range(16, 20));
         cl = (ne == 16) && ($urandom_range(0, 1) == 1);
         run_frame(w, ne, cl, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
